// File: rtl/th99_bus_regfile_if.sv
// Control and address strobes of the TH99 multiplexed CPU bus.
// The bidirectional data bus stays a plain inout port on the slave.
interface th99_bus_regfile_if #(
    parameter int unsigned AB_W = 8
) ();
    logic            cs_n;
    logic            ale;
    logic            r_n;
    logic            w_n;
    logic [AB_W-1:0] abus;

    modport master (output cs_n, ale, r_n, w_n, abus);
    modport slave  (input  cs_n, ale, r_n, w_n, abus);
endinterface

// File: rtl/th99_bus_regfile.sv
// TH99 CPU bus slave: decodes the asynchronous multiplexed bus into register-file
// accesses and presents the register file as a wide display word.
module th99_bus_regfile #(
    parameter int unsigned AB_W       = 8,
    parameter int unsigned DW         = 8,
    parameter int unsigned ADDR_BYTES = 2,
    parameter int unsigned NREGS      = 9,
    parameter int unsigned DISP_W     = 66,
    parameter int unsigned AUTO_INC   = 0
) (
    input  logic                clock,
    input  logic                rst_n,
    th99_bus_regfile_if.slave   bus,
    inout  wire  [DW-1:0]       dbus,
    output logic [DISP_W-1:0]   display,
    output logic                err
);
    localparam int unsigned ADDR_W = AB_W * ADDR_BYTES;
    localparam int unsigned CNT_W  = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam int unsigned IDX_W  = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned FLAT_W = NREGS * DW;
    localparam int unsigned S_CS   = 3;
    localparam int unsigned S_ALE  = 2;
    localparam int unsigned S_RD   = 1;
    localparam int unsigned S_WR   = 0;

    typedef enum logic [2:0] {IDLE, ADDR, READY, READ, WRITE} state_e;

    state_e              state_q, state_d;
    logic [3:0]          sync1_q, sync2_q;
    logic                ale_prev_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic                oe_q, oe_d;
    logic                err_q, err_d;
    logic                conflict_q, conflict_d;
    logic [DW-1:0]       regs_q [NREGS];
    logic [DW-1:0]       regs_d [NREGS];
    logic [DISP_W-1:0]   display_q, display_d;

    logic                cs_s, ale_s, r_s, w_s, w_pre, ale_fall;
    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic [DW-1:0]       rd_val;
    logic [ADDR_W-1:0]   addr_inc, addr_shift;
    logic [FLAT_W-1:0]   flat;

    assign cs_s     = sync2_q[S_CS];
    assign ale_s    = sync2_q[S_ALE];
    assign r_s      = sync2_q[S_RD];
    assign w_s      = sync2_q[S_WR];
    // Value w_s takes next cycle: gating oe with it keeps oe_q low whenever w_s is low.
    assign w_pre    = sync1_q[S_WR];
    assign ale_fall = ale_prev_q & ~ale_s;

    assign in_range   = addr_q < ADDR_W'(NREGS);
    assign idx        = IDX_W'(addr_q);
    assign rd_val     = in_range ? regs_q[idx] : '0;
    assign addr_inc   = addr_q + ADDR_W'(1);
    assign addr_shift = ADDR_W'({addr_q, bus.abus});

    // Next-state and datapath for the bus FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        oe_d       = 1'b0;
        err_d      = err_q;
        conflict_d = conflict_q;
        regs_d     = regs_q;

        if (cs_s) begin
            state_d    = IDLE;
            byte_cnt_d = '0;
            conflict_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = ADDR;
                ADDR: begin
                    if (ale_fall) begin
                        addr_d = addr_shift;
                        if (byte_cnt_q == CNT_W'(ADDR_BYTES - 1)) begin
                            byte_cnt_d = '0;
                            state_d    = READY;
                        end else begin
                            byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        end
                    end
                end
                READY: begin
                    // A collision blocks any access until both strobes are back high.
                    if (!r_s && !w_s) begin
                        err_d      = 1'b1;
                        conflict_d = 1'b1;
                    end else if (conflict_q) begin
                        if (r_s && w_s) conflict_d = 1'b0;
                    end else if (!r_s) begin
                        state_d = READ;
                        rdata_d = rd_val;
                        oe_d    = w_pre;
                        if (!in_range) err_d = 1'b1;
                    end else if (!w_s) begin
                        state_d = WRITE;
                        wdata_d = dbus;
                    end else if (ale_fall) begin
                        addr_d = addr_shift;
                        if (ADDR_BYTES > 1) begin
                            byte_cnt_d = CNT_W'(1);
                            state_d    = ADDR;
                        end
                    end
                end
                READ: begin
                    if (!w_s) begin
                        err_d      = 1'b1;
                        conflict_d = 1'b1;
                        state_d    = READY;
                    end else if (r_s) begin
                        state_d = READY;
                        if (AUTO_INC != 0) addr_d = addr_inc;
                    end else begin
                        oe_d    = w_pre;
                        rdata_d = rd_val;
                    end
                end
                WRITE: begin
                    if (!r_s) begin
                        err_d      = 1'b1;
                        conflict_d = 1'b1;
                        state_d    = READY;
                    end else if (!w_s) begin
                        wdata_d = dbus;
                    end else begin
                        if (in_range) regs_d[idx] = wdata_q;
                        else          err_d       = 1'b1;
                        if (AUTO_INC != 0) addr_d = addr_inc;
                        state_d = READY;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Display word: reg0 in the LSBs, truncated or zero-padded to DISP_W.
    always_comb begin
        flat = '0;
        for (int unsigned i = 0; i < NREGS; i++) flat[i*DW +: DW] = regs_q[i];
        display_d = DISP_W'(flat);
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            ale_prev_q <= 1'b1;
            state_q    <= IDLE;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            oe_q       <= 1'b0;
            err_q      <= 1'b0;
            conflict_q <= 1'b0;
            regs_q     <= '{default: '0};
            display_q  <= '0;
        end else begin
            sync1_q    <= {bus.cs_n, bus.ale, bus.r_n, bus.w_n};
            sync2_q    <= sync1_q;
            ale_prev_q <= ale_s;
            state_q    <= state_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            oe_q       <= oe_d;
            err_q      <= err_d;
            conflict_q <= conflict_d;
            regs_q     <= regs_d;
            display_q  <= display_d;
        end
    end

    assign dbus    = oe_q ? rdata_q : {DW{1'bz}};
    assign display = display_q;
    assign err     = err_q;
endmodule
